// File: rtl/alien_formation.sv
// Invader formation: marches 3x5 aliens sideways, descends at the screen edges,
// removes aliens on kill requests and parks dead ones off-screen for the mapper.
module alien_formation #(
    parameter int COLS     = 5,
    parameter int ROWS     = 3,
    parameter int ALIEN_W  = 24,
    parameter int ALIEN_H  = 16,
    parameter int GAP_X    = 16,
    parameter int GAP_Y    = 12,
    parameter int X_START  = 100,
    parameter int Y_START  = 40,
    parameter int STEP_X   = 2,
    parameter int STEP_Y   = 8,
    parameter int X_MIN    = 0,
    parameter int X_MAX    = 639,
    parameter int Y_LIMIT  = 440,
    parameter int MOVE_DIV = 4
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   frame_clk,
    input  logic                   kill,
    input  logic [3:0]             kill_idx,
    output logic [9:0]             AlienX      [ROWS*COLS],
    output logic [9:0]             AlienY      [ROWS*COLS],
    output logic [9:0]             Alien_sizeX [ROWS*COLS],
    output logic [9:0]             Alien_sizeY [ROWS*COLS],
    output logic [ROWS*COLS-1:0]   alive,
    output logic                   all_dead,
    output logic                   invaded
);
    localparam int N     = ROWS * COLS;
    localparam int PX    = ALIEN_W + GAP_X;
    localparam int PY    = ALIEN_H + GAP_Y;
    localparam int DIV_W = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;

    localparam logic signed [11:0] XMAX_S = 12'(X_MAX);
    localparam logic signed [11:0] XMIN_S = 12'(X_MIN);
    localparam logic signed [11:0] YLIM_S = 12'(Y_LIMIT);

    typedef enum logic {MARCH, HALTED} state_t;

    state_t             state;
    logic [9:0]         org_x, org_y;
    logic               dir;
    logic [DIV_W-1:0]   div_cnt;
    logic [2:0]         sync;
    logic               tick;

    logic [COLS-1:0]    col_alive;
    logic [ROWS-1:0]    row_alive;
    int                 cmin, cmax, rmax;
    logic signed [11:0] right_sum, left_sum, bottom_sum;
    logic               descend;

    // sync[0..1] is the synchronizer, sync[2] the edge-detect history
    assign tick     = sync[1] & ~sync[2];
    assign all_dead = (alive == '0);

    always_comb begin
        col_alive = '0;
        row_alive = '0;
        for (int i = 0; i < N; i++) begin
            if (alive[i]) begin
                col_alive[i % COLS] = 1'b1;
                row_alive[i / COLS] = 1'b1;
            end
        end
        cmin = 0;
        cmax = 0;
        rmax = 0;
        for (int c = COLS - 1; c >= 0; c--)
            if (col_alive[c]) cmin = c;
        for (int c = 0; c < COLS; c++)
            if (col_alive[c]) cmax = c;
        for (int r = 0; r < ROWS; r++)
            if (row_alive[r]) rmax = r;
    end

    // Edge sums are done in 12-bit signed so a step past 0 or 1023 cannot wrap
    always_comb begin
        right_sum  = 12'(org_x) + 12'(cmax * PX + ALIEN_W - 1 + STEP_X);
        left_sum   = 12'(org_x) + 12'(cmin * PX) - 12'(STEP_X);
        bottom_sum = 12'(org_y) + 12'(STEP_Y + rmax * PY + ALIEN_H - 1);
        descend    = dir ? (left_sum < XMIN_S) : (right_sum > XMAX_S);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sync    <= '0;
            org_x   <= 10'(X_START);
            org_y   <= 10'(Y_START);
            dir     <= 1'b0;
            div_cnt <= '0;
            alive   <= '1;
            state   <= MARCH;
            invaded <= 1'b0;
        end else begin
            sync <= {sync[1:0], frame_clk};
            if (kill && int'(kill_idx) < N)
                alive[kill_idx] <= 1'b0;
            case (state)
                MARCH: begin
                    if (all_dead) begin
                        state <= HALTED;
                    end else if (tick) begin
                        if (div_cnt != DIV_W'(MOVE_DIV - 1)) begin
                            div_cnt <= div_cnt + DIV_W'(1);
                        end else begin
                            div_cnt <= '0;
                            if (descend) begin
                                org_y <= org_y + 10'(STEP_Y);
                                dir   <= ~dir;
                                if (bottom_sum >= YLIM_S) begin
                                    invaded <= 1'b1;
                                    state   <= HALTED;
                                end
                            end else if (dir) begin
                                org_x <= org_x - 10'(STEP_X);
                            end else begin
                                org_x <= org_x + 10'(STEP_X);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_alien
        assign AlienX[i]      = alive[i] ? org_x + 10'((i % COLS) * PX) : 10'h3FF;
        assign AlienY[i]      = alive[i] ? org_y + 10'((i / COLS) * PY) : 10'h3FF;
        assign Alien_sizeX[i] = 10'(ALIEN_W - 1);
        assign Alien_sizeY[i] = 10'(ALIEN_H - 1);
    end
endmodule

// File: doc/alien_formation.md
# alien_formation

Position and life-state generator for the 15-alien invader formation: 3 rows of 5. Once per N frames it marches the formation sideways, steps it down and reverses at the screen edges, and removes aliens on kill requests from the missile/collision logic. It drives the per-alien position and size arrays consumed directly by `color_mapper`. Dead aliens are parked off-screen so the mapper never draws them.

## Interface
Parameters:
- `COLS` = 5; `ROWS` = 3: formation shape. Index i maps to row = i/COLS, col = i%COLS, so rows are i = 0–4, 5–9 and 10–14.
- `ALIEN_W` = 24; `ALIEN_H` = 16: drawn alien size in pixels.
- `GAP_X` = 16; `GAP_Y` = 12: spacing between aliens. Column pitch is 40; row pitch is 28.
- `X_START` = 100; `Y_START` = 40: formation origin (top-left of alien 0) after reset.
- `STEP_X` = 2; `STEP_Y` = 8: march step and descend step, in pixels.
- `X_MIN` = 0; `X_MAX` = 639: horizontal playfield limits, inclusive.
- `Y_LIMIT` = 440: invasion line.
- `MOVE_DIV` = 4: frame ticks per formation move, ≥1.

Ports:
- `Clk` in 1: system clock.
- `Reset` in 1: synchronous, active-high.
- `frame_clk` in 1: VGA vertical sync, asynchronous to `Clk`.
- `kill` in 1: single-cycle request to remove one alien.
- `kill_idx` in 4: index of the alien to remove, 0–14.
- `AlienX[15]`, `AlienY[15]` out 10 each: top-left pixel of each alien.
- `Alien_sizeX[15]`, `Alien_sizeY[15]` out 10 each: constant `ALIEN_W-1` and `ALIEN_H-1`. The mapper test is inclusive.
- `alive` out 15: bit i = alien i alive.
- `all_dead` out 1: high when `alive` == 0.
- `invaded` out 1: high when the formation has reached `Y_LIMIT`.

## Operation
- **frame_clk handling:** `frame_clk` passes through a 2-FF synchronizer, then a rising-edge detector, producing a one-cycle `tick`.
- **State registers:**
  - `OrgX`, `OrgY`: 10 bits each.
  - `dir`: 0 = right, 1 = left.
  - `div_cnt`: range 0..`MOVE_DIV-1`.
  - `alive`: 15 bits.
  - State: `MARCH` or `HALTED`.
- **Position outputs:** `AlienX[i] = OrgX + col*(ALIEN_W+GAP_X)` and `AlienY[i] = OrgY + row*(ALIEN_H+GAP_Y)`. These are combinational from the registers.
  - Exception: if alive[i] = 0, `AlienX[i]` = `AlienY[i]` = 10'h3FF (off-screen).
- **Live extents:** derived combinationally from `alive`.
  - `cmin` / `cmax`: leftmost and rightmost column containing any live alien.
  - `rmax`: lowest row containing any live alien.
- **Edge arithmetic:** all edge sums use 12-bit signed values. There is no 10-bit wrap.
- **MARCH state:** on `tick`:
  - If `div_cnt` ≠ `MOVE_DIV-1`: `div_cnt`++.
  - Otherwise `div_cnt` ← 0 and a move is evaluated:
    - `dir` = 0: if `OrgX + cmax*40 + ALIEN_W-1 + STEP_X > X_MAX`, descend; else `OrgX += STEP_X`.
    - `dir` = 1: if `OrgX + cmin*40 - STEP_X < X_MIN`, descend; else `OrgX -= STEP_X`.
    - Descend: `OrgY += STEP_Y`, toggle `dir`, `OrgX` unchanged.
- **Invasion check:** after any descend, if `OrgY_new + rmax*28 + ALIEN_H-1 >= Y_LIMIT`, set `invaded` ← 1 and go to `HALTED`.
- **Kill requests:** when `kill` is high, `kill_idx` ≤ 14 and the alien is alive, clear `alive[kill_idx]`.
  - `kill_idx` 15 is ignored; killing an already-dead alien is a no-op.
  - Kills are accepted in both states.
- **Game-over by clearance:** `all_dead` = (`alive` == 0). When it is 1, the state goes to `HALTED` on the next cycle and no further moves occur.
- **HALTED state:** holds position; it is exited only by `Reset`.
- **Move with no live aliens:** if `alive` == 0 when a move is evaluated, no move occurs.

## Timing
- **Reset values:**
  - `OrgX` = 100, `OrgY` = 40, `dir` = 0, `div_cnt` = 0.
  - `alive` = 15'h7FFF, state = `MARCH`, `invaded` = 0, `all_dead` = 0.
  - Synchronizer flops = 0.
  - Resulting outputs: `AlienX[0]` = 100, `AlienX[4]` = 260, `AlienY[10]` = 96.
- **tick latency:** `tick` asserts on the 3rd `Clk` rising edge after `frame_clk` rises and lasts exactly 1 cycle. A `frame_clk` held high yields one tick.
- **Move latency:** origin registers update on the clock edge in which `tick` is high. Outputs reflect the change in the following cycle.
- **Kill latency:** the alive bit clears on the edge where `kill` is sampled high, and outputs park on the next cycle.
- **Kill and move in the same cycle:** the move evaluation uses the pre-kill `alive`. The kill still takes effect.
- **Reset during a move or kill:** `Reset` wins over all concurrent events.

## Test plan
- **Reset check:** assert `Reset` for 2 cycles → `AlienX[0..4]` = 100, 140, 180, 220, 260; `AlienY[0]` = 40, `AlienY[5]` = 68, `AlienY[10]` = 96; `alive` = 7FFF; sizes 23/15.
- **Move cadence and frame_clk sync:** apply 4 `frame_clk` pulses → `OrgX` = 102 after the 4th tick; 3 pulses → unchanged. A `frame_clk` held high for 1000 cycles → 1 tick.
- **Right-edge descend:** march from reset. After 178 moves `OrgX` = 456; the 179th move gives `OrgY` = 48, `dir` = 1, `OrgX` = 456.
- **Kill reshapes extents:** kill indices 4, 9, 14 → those outputs become 3FF. The right-edge descend now happens at `OrgX` = 496 instead of 456. Repeating `kill_idx` 4, and `kill_idx` 15, leave `alive` unchanged.
- **Invasion:** repeated descends until `OrgY` + 71 ≥ 440 (`OrgY` = 376 with all rows alive) → `invaded` = 1 and the position freezes. Killing rows 10–14 first delays invasion to `OrgY` + 43 ≥ 440.
- **Clearance, same-cycle kill+move, reset mid-kill:**
  - Kill all 15 → `all_dead` = 1, state `HALTED`, ticks ignored.
  - A kill in the same cycle as a move → both take effect.
  - `Reset` concurrent with `kill` → `alive` = 7FFF.
